// File: rtl/rumble_pattern_sequencer.sv
// Rumble motor / LED pattern sequencer: queues MMIO pattern commands and
// plays each as a train of on/off pulses timed in UNIT_CYCLES ticks.
module rumble_pattern_sequencer #(
   parameter int unsigned UNIT_CYCLES = 500000,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned CNT_W       = 3
) (
   input  logic        fastClock,
   input  logic        reset,
   input  logic        cmdWrite,
   input  logic [31:0] cmdWord,
   output logic        ledMotorOut,
   output logic        cmdFull,
   output logic        busy,
   output logic [31:0] mmioStatus
);
   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

   state_t           state_q;
   logic [19:0]      fifo_q [QUEUE_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [3:0]       pulses_q;
   logic [7:0]       on_q, off_q;
   logic [27:0]      timer_q;
   logic             overflow_q;
   logic             led_q;

   logic             is_abort, fifo_full, push_d, pop_d, pulse_done_d;
   logic [19:0]      head_d;
   logic [27:0]      head_on_cyc_d, on_cyc_d, off_cyc_d;
   logic             unused_bits;

   function automatic logic [27:0] unit_cycles(input logic [7:0] units);
      return 28'(units) * 28'(UNIT_CYCLES);
   endfunction

   function automatic logic [7:0] on_units(input logic [7:0] units);
      return (units == 8'd0) ? 8'd1 : units;
   endfunction

   assign unused_bits   = ^cmdWord[31:20];
   assign is_abort      = cmdWrite && (cmdWord[3:0] == 4'd0);
   assign fifo_full     = (count_q == CNT_W'(QUEUE_DEPTH));
   assign push_d        = cmdWrite && (cmdWord[3:0] != 4'd0) && !fifo_full;
   assign head_d        = fifo_q[rd_ptr_q];
   assign head_on_cyc_d = unit_cycles(on_units(head_d[11:4]));
   assign on_cyc_d      = unit_cycles(on_units(on_q));
   assign off_cyc_d     = unit_cycles(off_q);

   // A pulse ends when OFF expires, or when ON expires and the off phase is empty.
   assign pulse_done_d  = (timer_q == '0) &&
                          ((state_q == OFF) || ((state_q == ON) && (off_q == 8'd0)));
   assign pop_d         = (count_q != '0) &&
                          ((state_q == IDLE) || (pulse_done_d && (pulses_q < 4'd2)));

   always_ff @(posedge fastClock) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pulses_q   <= '0;
         on_q       <= '0;
         off_q      <= '0;
         timer_q    <= '0;
         overflow_q <= 1'b0;
         led_q      <= 1'b0;
      end else if (is_abort) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pulses_q <= '0;
         timer_q  <= '0;
         led_q    <= 1'b0;
      end else begin
         if (push_d) begin
            fifo_q[wr_ptr_q] <= cmdWord[19:0];
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (cmdWrite && fifo_full) begin
            overflow_q <= 1'b1;
         end
         if (pop_d) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push_d && !pop_d) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop_d && !push_d) begin
            count_q <= count_q - CNT_W'(1);
         end

         if (pop_d) begin
            pulses_q <= head_d[3:0];
            on_q     <= head_d[11:4];
            off_q    <= head_d[19:12];
            timer_q  <= head_on_cyc_d - 28'd1;
            led_q    <= 1'b1;
            state_q  <= ON;
         end else if (state_q == IDLE) begin
            led_q <= 1'b0;
         end else if (!pulse_done_d) begin
            if (timer_q != '0) begin
               timer_q <= timer_q - 28'd1;
            end else begin
               led_q   <= 1'b0;
               timer_q <= off_cyc_d - 28'd1;
               state_q <= OFF;
            end
         end else if (pulses_q >= 4'd2) begin
            pulses_q <= pulses_q - 4'd1;
            timer_q  <= on_cyc_d - 28'd1;
            led_q    <= 1'b1;
            state_q  <= ON;
         end else begin
            pulses_q <= '0;
            timer_q  <= '0;
            led_q    <= 1'b0;
            state_q  <= IDLE;
         end
      end
   end

   assign ledMotorOut = led_q;
   assign cmdFull     = fifo_full;
   assign busy        = (state_q != IDLE) || (count_q != '0);

   always_comb begin
      mmioStatus              = '0;
      mmioStatus[CNT_W-1:0]   = count_q;
      mmioStatus[8]           = busy;
      mmioStatus[9]           = overflow_q;
      mmioStatus[13:10]       = pulses_q;
   end
endmodule

// File: tb/tb_rumble_pattern_sequencer.sv
// Bench for rumble_pattern_sequencer: each command is expanded into its full
// per-cycle waveform in a queue and compared against the DUT every cycle.
module tb_rumble_pattern_sequencer;
   localparam int unsigned U = 4;
   localparam int unsigned D = 4;

   logic        fastClock = 1'b0;
   logic        reset     = 1'b1;
   logic        cmdWrite  = 1'b0;
   logic [31:0] cmdWord   = '0;
   logic        ledMotorOut, cmdFull, busy;
   logic [31:0] mmioStatus;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: pending commands, and the remaining levels of the
   // pattern being played, each tagged with its pulses-remaining value.
   logic [19:0] m_fifo [$];
   logic [4:0]  m_wave [$];
   bit          m_ovf, m_led, m_play;
   logic [3:0]  m_pul;

   always #5 fastClock = ~fastClock;

   rumble_pattern_sequencer #(
      .UNIT_CYCLES (U),
      .QUEUE_DEPTH (D),
      .CNT_W       (3)
   ) dut (
      .fastClock   (fastClock),
      .reset       (reset),
      .cmdWrite    (cmdWrite),
      .cmdWord     (cmdWord),
      .ledMotorOut (ledMotorOut),
      .cmdFull     (cmdFull),
      .busy        (busy),
      .mmioStatus  (mmioStatus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expand(input logic [19:0] c);
      int unsigned p, on, off;
      p   = c[3:0];
      on  = (c[11:4] == 8'd0) ? 1 : c[11:4];
      off = c[19:12];
      for (int unsigned k = 0; k < p; k++) begin
         for (int unsigned i = 0; i < on * U; i++)  m_wave.push_back({4'(p - k), 1'b1});
         for (int unsigned i = 0; i < off * U; i++) m_wave.push_back({4'(p - k), 1'b0});
      end
   endtask

   task automatic model_edge(input logic r, input logic w, input logic [31:0] word);
      int unsigned pre_sz;
      logic [4:0]  e;
      if (r) begin
         m_fifo.delete(); m_wave.delete();
         m_ovf = 0; m_led = 0; m_play = 0; m_pul = '0;
         return;
      end
      if (w && word[3:0] == 4'd0) begin
         m_fifo.delete(); m_wave.delete();
         m_led = 0; m_play = 0; m_pul = '0;
         return;
      end
      pre_sz = m_fifo.size();
      if (m_wave.size() == 0 && pre_sz != 0) expand(m_fifo.pop_front());
      if (m_wave.size() != 0) begin
         e = m_wave.pop_front();
         m_led = e[0]; m_pul = e[4:1]; m_play = 1;
      end else begin
         m_led = 0; m_pul = '0; m_play = 0;
      end
      if (w) begin
         if (pre_sz == D) m_ovf = 1;
         else m_fifo.push_back(word[19:0]);
      end
   endtask

   task automatic compare();
      logic [31:0] es;
      logic        eb;
      eb         = m_play || (m_fifo.size() != 0);
      es         = '0;
      es[2:0]    = 3'(m_fifo.size());
      es[8]      = eb;
      es[9]      = m_ovf;
      es[13:10]  = m_pul;
      chk("led",    32'(ledMotorOut), 32'(m_led));
      chk("busy",   32'(busy),        32'(eb));
      chk("full",   32'(cmdFull),     32'(m_fifo.size() == D));
      chk("status", mmioStatus,       es);
   endtask

   task automatic step(input logic r, input logic w, input logic [31:0] word);
      reset = r; cmdWrite = w; cmdWord = word;
      @(posedge fastClock);
      model_edge(r, w, word);
      #1;
      compare();
      reset = 1'b0; cmdWrite = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("rst_status", mmioStatus, 32'h0);
      chk("rst_led", 32'(ledMotorOut), 32'h0);

      // Single pulse, on 2 / off 1
      step(1'b0, 1'b1, 32'h0000_1021);
      step(1'b0, 1'b0, 32'h0);
      chk("lat_led", 32'(ledMotorOut), 32'h1);
      idle(16);
      chk("single_done", mmioStatus, 32'h0);

      // Three pulses, on 1 / off 1
      step(1'b0, 1'b1, 32'h0000_1013);
      idle(30);

      // Overflow with back-to-back queued patterns
      step(1'b0, 1'b1, 32'h0000_1011);
      step(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0000_1011 + (i << 4));
      chk("ovf_set", 32'(mmioStatus[9]), 32'h1);
      chk("full_set", 32'(cmdFull), 32'h1);
      idle(90);
      chk("ovf_sticky", 32'(mmioStatus[9]), 32'h1);

      // Abort mid-ON with two commands queued
      step(1'b0, 1'b1, 32'h0000_1031);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_1011);
      step(1'b0, 1'b1, 32'h0000_1012);
      idle(2);
      step(1'b0, 1'b1, 32'h0000_0000);
      chk("abort_led", 32'(ledMotorOut), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_ovf", 32'(mmioStatus[9]), 32'h1);
      idle(5);

      // Off phase of zero merges pulses
      step(1'b0, 1'b1, 32'h0000_0012);
      idle(12);

      // Reset while in OFF with FIFO non-empty
      step(1'b0, 1'b1, 32'h0000_1011);
      step(1'b0, 1'b1, 32'h0000_1011);
      step(1'b0, 1'b1, 32'h0000_1011);
      idle(3);
      step(1'b1, 1'b0, 32'h0);
      chk("rst_mid_status", mmioStatus, 32'h0);
      idle(20);
      chk("rst_mid_led", 32'(ledMotorOut), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0]  w;
         int unsigned  r;
         r        = $urandom_range(0, 99);
         w        = $urandom;
         w[3:0]   = 4'($urandom_range(1, 3));
         w[11:4]  = 8'($urandom_range(0, 2));
         w[19:12] = 8'($urandom_range(0, 2));
         if (r < 1) step(1'b1, 1'b0, w);
         else if (r < 3) begin
            w[3:0] = 4'd0;
            step(1'b0, 1'b1, w);
         end else if (r < 20) step(1'b0, 1'b1, w);
         else step(1'b0, 1'b0, w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
